// File: rtl/acc_sequencer.sv
// Fetch/execute sequencer for the 16-bit accumulator datapath.
// Two cycles per instruction: FETCH latches the ROM word, EXEC updates acc/flags/pc.
module acc_sequencer #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] acc,
    output logic              zero,
    output logic              carry,
    output logic              retire,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic                zero_q, zero_d;
    logic                carry_q, carry_d;
    logic                retire_q, retire_d;

    logic [7:0]          opcode;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic                acc_wr;

    assign opcode = instr_q[DATA_W-1:8];
    assign imm    = {{(DATA_W-8){1'b0}}, instr_q[7:0]};
    assign sum    = {1'b0, acc_q} + {1'b0, imm};
    // Top bit of the widened difference is the borrow (acc < imm).
    assign diff   = {1'b0, acc_q} - {1'b0, imm};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            acc_q    <= '0;
            instr_q  <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            retire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            acc_q    <= acc_d;
            instr_q  <= instr_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            retire_q <= retire_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        acc_d    = acc_q;
        instr_d  = instr_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        retire_d = 1'b0;
        acc_wr   = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (run) begin
                    instr_d = rom_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                retire_d = 1'b1;
                state_d  = S_FETCH;
                pc_d     = pc_q + ADDR_W'(1);
                case (opcode)
                    8'h00: begin
                        acc_d   = sum[DATA_W-1:0];
                        carry_d = sum[DATA_W];
                        acc_wr  = 1'b1;
                    end
                    8'h01: begin
                        acc_d   = diff[DATA_W-1:0];
                        carry_d = diff[DATA_W];
                        acc_wr  = 1'b1;
                    end
                    8'h02: begin
                        acc_d  = acc_q & imm;
                        acc_wr = 1'b1;
                    end
                    8'h03: begin
                        acc_d  = acc_q | imm;
                        acc_wr = 1'b1;
                    end
                    8'h04: begin
                        acc_d  = imm;
                        acc_wr = 1'b1;
                    end
                    8'h05: begin
                        acc_d  = acc_q << instr_q[3:0];
                        acc_wr = 1'b1;
                    end
                    8'h06: begin
                        acc_d  = acc_q >> instr_q[3:0];
                        acc_wr = 1'b1;
                    end
                    8'h07: pc_d = instr_q[ADDR_W-1:0];
                    8'hFF: begin
                        pc_d    = pc_q;
                        state_d = S_HALT;
                    end
                    default: ;
                endcase
                if (acc_wr) begin
                    zero_d = (acc_d == '0);
                end
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase
    end

    assign rom_addr = pc_q;
    assign acc      = acc_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign retire   = retire_q;
    assign halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_acc_sequencer.sv
// Self-checking bench for acc_sequencer: directed program steps plus random
// instructions, compared against an arithmetic reference model.
module tb_acc_sequencer;

    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          run = 1'b0;
    logic [15:0]   rom_data;
    logic [AW-1:0] rom_addr;
    logic [15:0]   acc;
    logic          zero, carry, retire, halted;

    logic [15:0]   rom [DEPTH];

    int n_pass = 0;
    int n_total = 0;

    int m_acc, m_pc;
    bit m_zero, m_carry, m_halted;

    acc_sequencer #(.ADDR_W(AW), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .rom_data(rom_data),
        .rom_addr(rom_addr), .acc(acc), .zero(zero), .carry(carry),
        .retire(retire), .halted(halted)
    );

    always #5 clk = ~clk;

    // Instruction ROM registered on the falling edge.
    always @(negedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_acc = 0; m_pc = 0; m_zero = 0; m_carry = 0; m_halted = 0;
    endtask

    task automatic model_exec(input logic [15:0] ins);
        int op, imm;
        longint s;
        op  = int'(ins[15:8]);
        imm = int'(ins[7:0]);
        if (op == 0) begin
            s = longint'(m_acc) + imm;
            m_carry = (s > 65535);
            m_acc = int'(s % 65536);
        end else if (op == 1) begin
            m_carry = (m_acc < imm);
            m_acc = (m_acc - imm + 65536) % 65536;
        end else if (op == 2) m_acc = m_acc & imm;
        else if (op == 3) m_acc = m_acc | imm;
        else if (op == 4) m_acc = imm;
        else if (op == 5) begin
            s = longint'(m_acc) * (longint'(1) << (imm % 16));
            m_acc = int'(s % 65536);
        end else if (op == 6) m_acc = m_acc / (1 << (imm % 16));
        if (op <= 6) m_zero = (m_acc == 0);
        if (op == 7) m_pc = imm % DEPTH;
        else if (op == 255) m_halted = 1;
        else m_pc = (m_pc + 1) % DEPTH;
    endtask

    // Entered #1 after a posedge with the DUT in FETCH and run=1.
    task automatic do_instr(input string tag);
        logic [15:0] ins;
        chk({tag, ":fetch_addr"}, 32'(rom_addr), m_pc);
        ins = rom[m_pc];
        @(posedge clk); #1;
        chk({tag, ":retire_lo"}, 32'(retire), 0);
        model_exec(ins);
        @(posedge clk); #1;
        chk({tag, ":retire_hi"}, 32'(retire), 1);
        chk({tag, ":acc"}, 32'(acc), m_acc);
        chk({tag, ":zero"}, 32'(zero), 32'(m_zero));
        chk({tag, ":carry"}, 32'(carry), 32'(m_carry));
        chk({tag, ":halted"}, 32'(halted), 32'(m_halted));
        chk({tag, ":next_addr"}, 32'(rom_addr), m_pc);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ":addr"}, 32'(rom_addr), 0);
        chk({tag, ":acc"}, 32'(acc), 0);
        chk({tag, ":zero"}, 32'(zero), 0);
        chk({tag, ":carry"}, 32'(carry), 0);
        chk({tag, ":retire"}, 32'(retire), 0);
        chk({tag, ":halted"}, 32'(halted), 0);
    endtask

    initial begin
        int exp1[8];
        int acc_hold;
        int opsel;
        logic [7:0] op8;
        exp1 = '{32'h0000, 32'h0070, 32'h0064, 32'h0190, 32'h0000, 32'h0080, 32'h0100, 32'h0000};
        rom = '{16'h0400, 16'h0070, 16'h010C, 16'h0502, 16'h0400, 16'h0080, 16'h0080, 16'h0400};

        #1 rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        run = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_instr($sformatf("prog1_%0d", i));
            chk($sformatf("prog1_lit_%0d", i), 32'(acc), exp1[i]);
        end
        chk("wrap_addr", 32'(rom_addr), 0);

        // Flag sequence, then pause at pc=3, NOP, then JMP 1 -> JMP 5.
        rom[0] = 16'h0400; rom[1] = 16'h0101; rom[2] = 16'h0001;
        rom[3] = 16'h3C05; rom[4] = 16'h0701;
        do_instr("mov0");
        chk("mov0_lit", {15'd0, zero, carry, acc}, {15'd0, 1'b1, 1'b0, 16'h0000});
        do_instr("sub1");
        chk("sub1_lit", {15'd0, zero, carry, acc}, {15'd0, 1'b0, 1'b1, 16'hFFFF});
        do_instr("add1");
        chk("add1_lit", {15'd0, zero, carry, acc}, {15'd0, 1'b1, 1'b1, 16'h0000});

        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("pause_addr_%0d", i), 32'(rom_addr), 3);
            chk($sformatf("pause_retire_%0d", i), 32'(retire), 0);
            chk($sformatf("pause_acc_%0d", i), 32'(acc), m_acc);
        end
        run = 1'b1;
        do_instr("nop3c");
        chk("nop_lit_addr", 32'(rom_addr), 4);

        rom[1] = 16'h0705;
        do_instr("jmp1");
        acc_hold = m_acc;
        do_instr("jmp5");
        chk("jmp5_lit_addr", 32'(rom_addr), 5);
        chk("jmp5_lit_acc", 32'(acc), acc_hold);

        for (int i = 0; i < 40; i++) begin
            opsel = int'($urandom_range(0, 9));
            op8 = (opsel < 8) ? 8'(opsel) : 8'($urandom_range(8, 254));
            rom[m_pc] = {op8, 8'($urandom_range(0, 255))};
            do_instr($sformatf("rand_%0d", i));
        end

        if (m_pc != 2) begin
            rom[m_pc] = 16'h0702;
            do_instr("jmp_to_2");
        end
        rom[2] = 16'hFF00;
        acc_hold = m_acc;
        do_instr("halt");
        chk("halt_lit", {30'd0, halted, retire}, {30'd0, 1'b1, 1'b1});
        for (int i = 0; i < 22; i++) begin
            run = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk($sformatf("halt_addr_%0d", i), 32'(rom_addr), 2);
            chk($sformatf("halt_flag_%0d", i), 32'(halted), 1);
            chk($sformatf("halt_retire_%0d", i), 32'(retire), 0);
            chk($sformatf("halt_acc_%0d", i), 32'(acc), acc_hold);
        end

        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("halt_rst");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        run = 1'b1;

        // Reset asserted while ADD 0x70 sits in EXEC with acc=0x10.
        rom[0] = 16'h0410; rom[1] = 16'h0070;
        do_instr("mov10");
        @(posedge clk); #1;
        chk("exec_retire_lo", 32'(retire), 0);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("exec_rst");
        @(posedge clk); #1;
        chk("exec_rst_hold_acc", 32'(acc), 0);
        model_reset();
        rst_n = 1'b1;
        rom[0] = 16'h0070;
        do_instr("post_rst_add");
        chk("post_rst_lit", 32'(acc), 32'h0070);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/acc_sequencer.md
Name: acc_sequencer

Overview:
- Fetch/execute sequencer for the 16-bit accumulator datapath.
- Drives the address of the negedge-registered instruction ROM and consumes its 16-bit instruction word.
- Instruction format: opcode = instr[15:8], 8-bit immediate = instr[7:0].
- Executes on an internal accumulator; exposes result, flags and a per-instruction retire strobe to downstream logic.

Parameters:
ADDR_W, 3, width of ROM address / program counter (ROM depth 2^ADDR_W)
DATA_W, 16, accumulator and instruction width (fixed at 16; immediate is always [7:0])

Ports:
clk  input  1  system clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
run  input  1  1 = sequencer may start a new fetch; 0 = hold at next fetch
rom_data  input  16  instruction from ROM (ROM registers it on negedge clk)
rom_addr  output  ADDR_W  registered program counter presented to ROM
acc  output  16  accumulator value
zero  output  1  1 when last acc-writing op produced 0
carry  output  1  carry/borrow from last ADD/SUB
retire  output  1  one-cycle pulse, high the cycle after an instruction executes
halted  output  1  high once HALT executes

Behaviour:
Reset (async, rst_n=0):
- rom_addr=0, acc=0, zero=0, carry=0, retire=0, halted=0.
- instr register=0x0000; state=FETCH.
- Reset mid-instruction discards that instruction entirely; no partial acc/flag update.

State machine (posedge):
- FETCH:
  - rom_addr holds pc; ROM updates rom_data on the mid-cycle negedge.
  - run=1: capture rom_data into instr register; go EXEC.
  - run=0: stay in FETCH; pc and acc unchanged.
- EXEC:
  - Decode instr; update acc/flags; update pc; go FETCH.
  - Always completes regardless of run.
- HALT: entered from EXEC on opcode 0xFF; halted=1; absorbing until reset.

Timing:
- 2 cycles per instruction.
- retire=1 for exactly the one cycle following each EXEC, including the EXEC of HALT.
- acc/flags are visible in that same retire cycle.

Opcodes (imm zero-extended to 16 bits; all arithmetic mod 2^16):
- 0x00 ADD: acc<=acc+imm; carry=bit 16 of the 17-bit sum.
- 0x01 SUB: acc<=acc-imm; carry=1 iff acc<imm (borrow).
- 0x02 AND: acc<=acc&imm.
- 0x03 OR: acc<=acc|imm.
- 0x04 MOV: acc<=imm.
- 0x05 SHL: acc<=acc<<imm[3:0]; vacated bits=0.
- 0x06 SHR: logical acc>>imm[3:0].
- 0x07 JMP: pc<=imm[ADDR_W-1:0]; acc and flags unchanged.
- 0xFF HALT: pc, acc and flags unchanged.
- Any other opcode: NOP; only pc advances.

Flags:
- zero updated by opcodes 0x00-0x06 only.
- carry updated by ADD and SUB only; held otherwise.

Program counter:
- pc<=pc+1 after every non-JMP, non-HALT EXEC.
- Wraps from 2^ADDR_W-1 to 0 with no flag or stall.
- JMP to the current address is legal (tight loop).

Test Plan:
- Load the ROM with 0400,0070,010C,0502,0400,0080,0080,0400; run=1 from reset -> acc after each retire: 0000,0070,0064,0190,0000,0080,0100,0000. Ninth fetch is at rom_addr=0 (wrap). Retire interval exactly 2 cycles.
- MOV 0; SUB 1; ADD 1 -> acc 0000 (zero=1, carry=0), then FFFF (zero=0, carry=1), then 0000 (zero=1, carry=1).
- run=0 held 5 cycles while in FETCH at pc=3 -> rom_addr stays 3, no retire, acc unchanged. run=1 -> resumes at pc 3.
- 0x07 JMP 05 at pc=1 -> next rom_addr=5; acc, zero and carry unchanged.
- 0xFF HALT at pc=2 -> one retire pulse, then halted=1; rom_addr stays 2 for 20+ cycles regardless of run. rst_n pulse -> all outputs return to reset values.
- Assert rst_n=0 asynchronously during EXEC of ADD 0x70 with acc=0x10 -> acc=0 immediately, not 0x80. Opcode 0x3C behaves as NOP: pc+1, acc and flags unchanged.
